// File: rtl/ili_pkg.sv
// -----------------------------------------------------------------------------
// ili_pkg
// Shared definitions for the ILI-style panel fill controller: panel command
// opcodes, default panel geometry, the controller state enum, the byte-position
// enum that walks the transmitted stream, and a rectangle-area helper.
// No ports (package).
// -----------------------------------------------------------------------------
package ili_pkg;

   // Panel command opcodes (sent with dc=0)
   localparam logic [7:0] CMD_CASET = 8'h2A;  // column address set
   localparam logic [7:0] CMD_PASET = 8'h2B;  // page (row) address set
   localparam logic [7:0] CMD_RAMWR = 8'h2C;  // memory write

   // Default panel geometry: highest legal column / row index
   localparam int DEFAULT_MAX_X = 239;
   localparam int DEFAULT_MAX_Y = 319;

   localparam int COORD_W = 9;
   localparam int PIX_W   = 17;  // wide enough for 240*320 = 76800 pixels

   typedef enum logic [1:0] {
      S_IDLE,
      S_SEND,
      S_WAIT,
      S_DONE
   } state_t;

   // Position within the outgoing byte stream. The eleven header bytes are
   // walked once; the pixel phase then alternates B_PIX_HI / B_PIX_LO.
   typedef enum logic [3:0] {
      B_CASET,
      B_X0_HI,
      B_X0_LO,
      B_X1_HI,
      B_X1_LO,
      B_PASET,
      B_Y0_HI,
      B_Y0_LO,
      B_Y1_HI,
      B_Y1_LO,
      B_RAMWR,
      B_PIX_HI,
      B_PIX_LO
   } byte_pos_t;

   // Upper byte of a 9-bit coordinate as sent on the wire
   function automatic logic [7:0] coord_hi(input logic [COORD_W-1:0] v);
      return {7'd0, v[COORD_W-1]};
   endfunction

   // Pixel count of an inclusive rectangle. Only meaningful for a legal
   // rectangle (x0<=x1, y0<=y1); the caller gates its use accordingly.
   function automatic logic [PIX_W-1:0] rect_area(
      input logic [COORD_W-1:0] x0,
      input logic [COORD_W-1:0] x1,
      input logic [COORD_W-1:0] y0,
      input logic [COORD_W-1:0] y1
   );
      logic [9:0]  w;
      logic [9:0]  h;
      logic [19:0] prod;
      w    = {1'b0, x1} - {1'b0, x0} + 10'd1;
      h    = {1'b0, y1} - {1'b0, y0} + 10'd1;
      prod = {10'd0, w} * {10'd0, h};
      return prod[PIX_W-1:0];
   endfunction

endpackage

// File: rtl/ili_pix_counter.sv
// -----------------------------------------------------------------------------
// ili_pix_counter
// 17-bit down-counter tracking how many pixels of the current fill have not yet
// had their low byte issued.
//   clk      : clock, rising edge
//   rst      : synchronous active-high reset, clears the count
//   load     : load load_val (takes priority over dec)
//   load_val : initial pixel count
//   dec      : decrement by one (saturates at zero)
//   zero     : count is zero
// -----------------------------------------------------------------------------
module ili_pix_counter
   import ili_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [PIX_W-1:0] load_val,
   input  logic             dec,
   output logic             zero
);

   logic [PIX_W-1:0] count_q;

   // NOTE: clocked state uses non-blocking assignments so every register
   // samples pre-edge values, independent of block evaluation order.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else if (load) begin
         count_q <= load_val;
      end else if (dec && (count_q != '0)) begin
         count_q <= count_q - 1'b1;
      end
   end

   assign zero = (count_q == '0);

endmodule

// File: rtl/ili_fill_ctrl.sv
// -----------------------------------------------------------------------------
// ili_fill_ctrl
// Streams the command/parameter/pixel bytes that fill a rectangle of an
// ILI-style panel with one RGB565 colour, handshaking byte-by-byte with an
// external SPI byte engine.
//
// Stream: CASET x0hi x0lo x1hi x1lo  PASET y0hi y0lo y1hi y1lo  RAMWR
//         then {color[15:8], color[7:0]} once per pixel.
//
// Parameters
//   MAX_X, MAX_Y : highest legal column / row index
// Ports
//   clk       : clock, rising edge
//   rst       : synchronous active-high reset
//   start     : one-cycle fill request (accepted only when idle and init_done)
//   x0,x1     : inclusive column bounds, captured on an accepted start
//   y0,y1     : inclusive row bounds, captured on an accepted start
//   color     : RGB565 fill value, captured on an accepted start
//   init_done : panel initialisation complete
//   sent      : one-cycle pulse, current byte has been shifted out
//   data      : byte to transmit (held from send until sent)
//   dc        : 0 = command byte, 1 = parameter/pixel byte
//   cs        : active-low panel select
//   send      : one-cycle request to transmit data
//   busy      : a fill is in progress
//   done      : one-cycle pulse at the end of a fill
//   err       : one-cycle pulse when a start carried an illegal rectangle
// -----------------------------------------------------------------------------
module ili_fill_ctrl
   import ili_pkg::*;
#(
   parameter int MAX_X = DEFAULT_MAX_X,
   parameter int MAX_Y = DEFAULT_MAX_Y
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [COORD_W-1:0] x0,
   input  logic [COORD_W-1:0] x1,
   input  logic [COORD_W-1:0] y0,
   input  logic [COORD_W-1:0] y1,
   input  logic [15:0]        color,
   input  logic               init_done,
   input  logic               sent,
   output logic [7:0]         data,
   output logic               dc,
   output logic               cs,
   output logic               send,
   output logic               busy,
   output logic               done,
   output logic               err
);

   localparam logic [COORD_W-1:0] MAX_X_C = COORD_W'(MAX_X);
   localparam logic [COORD_W-1:0] MAX_Y_C = COORD_W'(MAX_Y);

   state_t             state_q;
   state_t             state_d;
   byte_pos_t          pos_q;
   byte_pos_t          pos_next;

   logic [COORD_W-1:0] x0_q;
   logic [COORD_W-1:0] x1_q;
   logic [COORD_W-1:0] y0_q;
   logic [COORD_W-1:0] y1_q;
   logic [15:0]        color_q;

   logic [7:0]         data_q;
   logic               dc_q;
   logic               err_q;

   logic [7:0]         byte_next;
   logic               dc_next;

   logic               accept;
   logic               bad_rect;
   logic               launch;
   logic               wait_sent;
   logic               last_byte;
   logic               advance;
   logic               pix_zero;
   logic               pix_dec;

   // ---------------------------------------------------------------------------
   // Request qualification
   // ---------------------------------------------------------------------------
   assign accept   = (state_q == S_IDLE) && start && init_done;
   assign bad_rect = (x0 > x1) || (y0 > y1) || (x1 > MAX_X_C) || (y1 > MAX_Y_C);
   assign launch   = accept && !bad_rect;

   // The counter is decremented as each low pixel byte is issued, so while
   // waiting on that byte a zero count means it is the final byte of the fill.
   assign wait_sent = (state_q == S_WAIT) && sent;
   assign last_byte = (pos_q == B_PIX_LO) && pix_zero;
   assign advance   = wait_sent && !last_byte;
   assign pix_dec   = (state_q == S_SEND) && (pos_q == B_PIX_LO);

   ili_pix_counter u_pix_counter (
      .clk      (clk),
      .rst      (rst),
      .load     (launch),
      .load_val (rect_area(x0, x1, y0, y1)),
      .dec      (pix_dec),
      .zero     (pix_zero)
   );

   // ---------------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------------------------------------------------------------------
   // FSM: next-state logic
   // ---------------------------------------------------------------------------
   // NOTE: every combinational output gets a default before the case so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (launch) state_d = S_SEND;
         S_SEND:  state_d = S_WAIT;
         S_WAIT:  if (sent) state_d = last_byte ? S_DONE : S_SEND;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // FSM: outputs
   // ---------------------------------------------------------------------------
   always_comb begin
      send = (state_q == S_SEND);
      busy = (state_q != S_IDLE);
      done = (state_q == S_DONE);
      cs   = !((state_q == S_SEND) || (state_q == S_WAIT));
      data = data_q;
      dc   = dc_q;
      err  = err_q;
   end

   // ---------------------------------------------------------------------------
   // Byte sequencing
   // ---------------------------------------------------------------------------
   // After RAMWR the stream loops between the two pixel bytes.
   always_comb begin
      pos_next = B_CASET;
      if (pos_q == B_PIX_LO) begin
         pos_next = B_PIX_HI;
      end else begin
         pos_next = byte_pos_t'(pos_q + 4'd1);
      end
   end

   // Content of the byte at pos_next, built from the captured request
   always_comb begin
      byte_next = 8'h00;
      dc_next   = 1'b1;
      unique case (pos_next)
         B_CASET:  begin byte_next = CMD_CASET; dc_next = 1'b0; end
         B_X0_HI:  byte_next = coord_hi(x0_q);
         B_X0_LO:  byte_next = x0_q[7:0];
         B_X1_HI:  byte_next = coord_hi(x1_q);
         B_X1_LO:  byte_next = x1_q[7:0];
         B_PASET:  begin byte_next = CMD_PASET; dc_next = 1'b0; end
         B_Y0_HI:  byte_next = coord_hi(y0_q);
         B_Y0_LO:  byte_next = y0_q[7:0];
         B_Y1_HI:  byte_next = coord_hi(y1_q);
         B_Y1_LO:  byte_next = y1_q[7:0];
         B_RAMWR:  begin byte_next = CMD_RAMWR; dc_next = 1'b0; end
         B_PIX_HI: byte_next = color_q[15:8];
         B_PIX_LO: byte_next = color_q[7:0];
         default:  begin byte_next = 8'h00; dc_next = 1'b0; end
      endcase
   end

   // data/dc are registered and only change on launch or on a non-final sent,
   // which keeps them stable for the whole send..sent window.
   always_ff @(posedge clk) begin
      if (rst) begin
         pos_q   <= B_CASET;
         data_q  <= 8'h00;
         dc_q    <= 1'b0;
         err_q   <= 1'b0;
         x0_q    <= '0;
         x1_q    <= '0;
         y0_q    <= '0;
         y1_q    <= '0;
         color_q <= '0;
      end else begin
         err_q <= accept && bad_rect;
         if (launch) begin
            x0_q    <= x0;
            x1_q    <= x1;
            y0_q    <= y0;
            y1_q    <= y1;
            color_q <= color;
            pos_q   <= B_CASET;
            data_q  <= CMD_CASET;
            dc_q    <= 1'b0;
         end else if (advance) begin
            pos_q  <= pos_next;
            data_q <= byte_next;
            dc_q   <= dc_next;
         end
      end
   end

endmodule

// File: doc/ili_fill_ctrl.md
ILI_FILL_CTRL -- requirements
Module: ili_fill_ctrl

Interface
REQ-001 The block SHALL have parameter MAX_X, default 239, giving the highest legal column index.
REQ-002 The block SHALL have parameter MAX_Y, default 319, giving the highest legal row index.
REQ-003 The block SHALL have a single clock, clk (input, 1), with all logic on its rising edge.
REQ-004 The block SHALL have reset rst (input, 1), synchronous and active-high.
REQ-005 The block SHALL have start (input, 1): one-cycle request to fill a rectangle.
REQ-006 The block SHALL have x0, x1 (input, 9 each): inclusive column bounds, sampled on an accepted start.
REQ-007 The block SHALL have y0, y1 (input, 9 each): inclusive row bounds, sampled on an accepted start.
REQ-008 The block SHALL have color (input, 16): RGB565 fill value, sampled on an accepted start.
REQ-009 The block SHALL have init_done (input, 1): high once panel initialisation is complete.
REQ-010 The block SHALL have sent (input, 1): one-cycle pulse from the SPI byte engine marking completion of the current byte.
REQ-011 The block SHALL have data (output, 8): the byte to transmit.
REQ-012 The block SHALL have dc (output, 1): 0 for a command byte, 1 for a parameter or pixel byte.
REQ-013 The block SHALL have cs (output, 1): active-low panel select.
REQ-014 The block SHALL have send (output, 1): one-cycle pulse requesting transmission of data.
REQ-015 The block SHALL have busy (output, 1), done (output, 1, one-cycle pulse) and err (output, 1, one-cycle pulse).

Function
REQ-016 The block SHALL accept start only in S_IDLE with init_done=1; otherwise start SHALL be ignored with no output change.
REQ-017 If x0>x1, y0>y1, x1>MAX_X or y1>MAX_Y on an accepted start, the block SHALL pulse err in the next cycle, stay in S_IDLE and issue no send.
REQ-018 The block SHALL use states S_IDLE, S_SEND, S_WAIT and S_DONE: IDLE->SEND on a valid start; SEND->WAIT unconditionally; WAIT->SEND on sent with bytes remaining; WAIT->DONE on sent after the last byte; DONE->IDLE unconditionally.
REQ-019 The block SHALL emit bytes in this order: 0x2A(dc0), 0x00|x0[8], x0[7:0], 0x00|x1[8], x1[7:0] (dc1), 0x2B(dc0), y0 hi, y0 lo, y1 hi, y1 lo (dc1), 0x2C(dc0), then color[15:8], color[7:0] (dc1) per pixel.
REQ-020 The pixel count SHALL be (x1-x0+1)*(y1-y0+1), computed in 17 bits, with a maximum of 76800 for the default parameters.
REQ-021 The first send SHALL pulse in the cycle after start is accepted, with data=0x2A, dc=0 and cs=0 in that same cycle.
REQ-022 send SHALL be high only in S_SEND, and data and dc SHALL hold stable from that send until the matching sent.
REQ-023 A sent pulse outside S_WAIT SHALL be ignored.
REQ-024 The next send SHALL pulse exactly one cycle after each non-final sent.
REQ-025 In S_DONE, done SHALL pulse and cs SHALL go to 1 in the same cycle.
REQ-026 busy SHALL be 1 in every state other than S_IDLE.

Reset
REQ-027 While rst=1, the block SHALL enter S_IDLE and drive cs=1, send=0, done=0, err=0, busy=0, data=0x00 and dc=0, and SHALL clear all counters.
REQ-028 Reset asserted mid-stream SHALL abort the transfer, with cs=1 in the cycle after rst is sampled and no done pulse.

Structure
REQ-029 A shared package ili_pkg SHALL hold the opcodes CMD_CASET=0x2A, CMD_PASET=0x2B and CMD_RAMWR=0x2C, the state enum, and the MAX_X and MAX_Y defaults.
REQ-030 A single sub-module, ili_pix_counter, SHALL be used: a 17-bit down-counter with load and decrement inputs and a zero flag.

Verification
REQ-031 Rectangle (0,0)-(0,0) with color 0xF800 SHALL produce the stream 2A 00 00 00 00 2B 00 00 00 00 2C F8 00, with dc pattern 0111101111011, then done.
REQ-032 Rectangle (0,0)-(239,319) with color 0x001F SHALL produce 11+153600 sends, a final byte of 0x1F, and one done pulse.
REQ-033 x0=10, x1=5 SHALL pulse err one cycle later, issue no send, and keep cs=1.
REQ-034 A second start issued mid-stream, and any start issued with init_done=0, SHALL be ignored, leaving the byte count unchanged.
REQ-035 sent delayed by 0 to 20 random cycles SHALL leave data and dc held, and the next send SHALL follow exactly one cycle after each sent.
REQ-036 rst asserted after byte 12 of a 4-pixel fill SHALL produce cs=1 on the next cycle with no done pulse, and a following fill SHALL complete correctly.
